// File: rtl/pos_err_mon.sv
// Position-error monitor: timestamps decoder error strobes into a show-ahead FIFO,
// keeps a saturating error total and raises a sticky alarm on error bursts within a window.
module pos_err_mon #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     err_vld,
  input  logic                     clr,
  input  logic [15:0]              win_len,
  input  logic [3:0]               alarm_th,
  input  logic                     rd_en,
  output logic [TS_W-1:0]          rd_data,
  output logic                     rd_vld,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     ovf,
  output logic [CNT_W-1:0]         err_total,
  output logic                     alarm
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    IDLE,
    ARMED
  } state_e;

  logic [TS_W-1:0]  ts_q;
  logic [TS_W-1:0]  mem_q [DEPTH];

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW-1:0]    rptr_nxt;
  logic [AW:0]      cnt_q, cnt_d;
  logic [TS_W-1:0]  head_q, head_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] tot_q, tot_d;

  state_e           state_q, state_d;
  logic [15:0]      wcnt_q, wcnt_d;
  logic [3:0]       hit_q, hit_d;
  logic [3:0]       hit_next;
  logic [3:0]       hit_inc;
  logic             alarm_q, alarm_d;

  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign pop      = rd_en & ~empty & ~clr;
  assign push     = err_vld & ~clr & (~full | pop);
  assign drop     = err_vld & ~clr & full & ~pop;
  assign rptr_nxt = rptr_q + AW'(1);

  // Free-running timestamp; deliberately untouched by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= ts_q;
    end
  end

  // head_q is a registered copy of the FIFO head so rd_data can hold while empty.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    ovf_d  = ovf_q;
    tot_d  = tot_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
      tot_d  = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_d = rptr_nxt;
      end
      if (push && !pop) begin
        cnt_d = cnt_q + (AW+1)'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - (AW+1)'(1);
      end
      if (push && (empty || (pop && cnt_q == (AW+1)'(1)))) begin
        head_d = ts_q;
      end else if (pop && cnt_q != (AW+1)'(1)) begin
        head_d = mem_q[rptr_nxt];
      end
      if (drop) begin
        ovf_d = 1'b1;
      end
      if (err_vld && tot_q != '1) begin
        tot_d = tot_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      head_q <= '0;
      ovf_q  <= 1'b0;
      tot_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      ovf_q  <= ovf_d;
      tot_q  <= tot_d;
    end
  end

  assign hit_inc = (hit_q == 4'd15) ? 4'd15 : hit_q + 4'(err_vld);

  // hit_next includes this cycle's error so the alarm can trip on the final in-window hit.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    hit_d    = hit_q;
    hit_next = hit_q;
    alarm_d  = alarm_q;
    case (state_q)
      IDLE: begin
        if (err_vld) begin
          hit_next = 4'd1;
          hit_d    = 4'd1;
          if (win_len != 16'd0) begin
            state_d = ARMED;
            wcnt_d  = win_len;
          end
        end
      end
      ARMED: begin
        hit_next = hit_inc;
        hit_d    = hit_inc;
        wcnt_d   = wcnt_q - 16'd1;
        if (wcnt_q == 16'd1) begin
          state_d = IDLE;
          hit_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (alarm_th != 4'd0 && hit_next >= alarm_th) begin
      alarm_d = 1'b1;
    end
    if (clr) begin
      state_d = IDLE;
      wcnt_d  = 16'd0;
      hit_d   = 4'd0;
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= 16'd0;
      hit_q   <= 4'd0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      hit_q   <= hit_d;
      alarm_q <= alarm_d;
    end
  end

  assign rd_data   = head_q;
  assign rd_vld    = ~empty;
  assign fifo_cnt  = cnt_q;
  assign ovf       = ovf_q;
  assign err_total = tot_q;
  assign alarm     = alarm_q;

endmodule

// File: doc/pos_err_mon.md
Name: pos_err_mon

Overview:
- Downstream consumer of the position-decode error strobe (err_vld, one pulse per failing 4-sample word).
- Timestamps each error and buffers the timestamps in a small show-ahead FIFO for the host/readout.
- Keeps a saturating total error count.
- Raises a sticky alarm when too many errors fall inside a programmable window that starts at the first error.

Parameters:
TS_W, 16, timestamp counter width
DEPTH, 8, FIFO depth in entries; power of 2, minimum 2
CNT_W, 16, width of the total error counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
err_vld  in  1  error strobe from position decoder, one cycle per event
clr  in  1  synchronous clear of monitor state
win_len  in  16  window length in cycles after the starting error
alarm_th  in  4  error count that trips the alarm; 0 disables the alarm
rd_en  in  1  pop request
rd_data  out  TS_W  timestamp at FIFO head
rd_vld  out  1  FIFO not empty
fifo_cnt  out  log2(DEPTH)+1  current occupancy
ovf  out  1  sticky: an error was dropped because the FIFO was full
err_total  out  CNT_W  saturating count of all accepted err_vld pulses
alarm  out  1  sticky window alarm

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: ts=0, FIFO empty, rd_vld=0, rd_data=0, fifo_cnt=0, ovf=0, err_total=0, alarm=0, FSM in IDLE, hit=0.
- Timestamp counter ts: free-running, +1 every cycle, wraps from 2^TS_W-1 to 0. Not affected by clr.
- Push: err_vld=1 in cycle t writes the value of ts during cycle t. Latency: rd_vld is high the cycle after the push edge.
- Pop: show-ahead FIFO.
  - rd_data always shows the head entry; it holds its last value while empty.
  - Pop occurs when rd_en=1 and rd_vld=1.
  - rd_en while empty is ignored; nothing changes.
- Full:
  - Push with no pop: the new entry is dropped; ovf is set to 1 (sticky); err_total still increments.
  - Push and pop in the same cycle: both succeed; occupancy is unchanged; ovf is not set.
- Empty with push, no pop: fifo_cnt goes 0 to 1. Read/write pointers wrap modulo DEPTH.
- err_total: +1 per err_vld; saturates at 2^CNT_W-1.
- Window FSM, states IDLE and ARMED:
  - IDLE with err_vld=1 (start cycle S): hit<=1. If win_len!=0, go to ARMED and set wcnt<=win_len. If win_len=0, stay in IDLE; hit is cleared on the next start.
  - ARMED, each cycle: hit += err_vld, saturating at 15; wcnt -= 1. When wcnt==1, go to IDLE and set hit<=0.
  - The window therefore covers cycles S through S+win_len.
  - An error in the first IDLE cycle after expiry starts a new window.
  - win_len and alarm_th are sampled every cycle. They must be held stable by software while a window is open.
- Alarm:
  - Let hit_next be the hit value including the current cycle's err_vld.
  - alarm<=1 when alarm_th!=0 and hit_next>=alarm_th. alarm is registered, so it rises one cycle after the triggering err_vld.
  - alarm stays set until reset or clr.
  - alarm_th=1: alarm rises the cycle after the first error.
- clr=1 (synchronous, highest priority): empties the FIFO and clears ovf, err_total, alarm and hit; FSM returns to IDLE. An err_vld or rd_en in the same cycle is discarded. ts keeps running.
- Asynchronous reset mid-operation: all state returns to reset values immediately. No partial pop or push survives.

Test Plan:
1. Reset, then err_vld pulses at ts=5, 9, 20 -> rd_vld=1 from ts=6; pops return 5, 9, 20 in order; fifo_cnt goes 3,2,1,0; then rd_vld=0.
2. DEPTH=8: 10 errors with no reads -> fifo_cnt=8, ovf=1, err_total=10. Then err_vld and rd_en in the same cycle while full -> fifo_cnt stays 8, no further drop.
3. win_len=10, alarm_th=3: errors at S, S+4, S+10 -> alarm=1 at S+11. Repeat with errors at S, S+4, S+11 -> alarm stays 0, and S+11 starts a new window with hit=1.
4. alarm_th=0: 20 back-to-back errors -> alarm stays 0; err_total=20.
5. Pulse clr while FIFO holds 4 entries, alarm=1 and err_vld=1 -> next cycle fifo_cnt=0, ovf=0, alarm=0, err_total=0, FSM in IDLE; ts not reset.
6. Set ts near wrap (TS_W=16) with errors at 65535 and 0 -> entries read back 65535 then 0. Assert rst_n low mid-window -> all outputs return to 0 asynchronously.
